// File: rtl/uart_rx_os_if.sv
// -----------------------------------------------------------------------------
// uart_rx_os_if
// Byte-side handshake bundle of the oversampling UART receiver.
//   rx_data     [7:0] last received byte               (receiver -> consumer)
//   rx_valid          rx_data holds an unread byte       (receiver -> consumer)
//   rx_ack            consumer took rx_data              (consumer -> receiver)
//   rx_busy           frame in progress                  (receiver -> consumer)
//   frame_err         1-clk pulse, stop bit sampled 0    (receiver -> consumer)
//   overrun_err       1-clk pulse, unread byte replaced  (receiver -> consumer)
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_os_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err,
    output overrun_err,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err,
    input  overrun_err,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// Oversampling UART receiver, 8N1, LSB first. The serial input is brought into
// the clock domain by a 2-FF synchroniser, a fractional accumulator produces
// OVERSAMPLE ticks per bit, each bit is decided by a 3-sample majority vote
// around the bit centre, and a completed byte is held with a valid/ack
// handshake.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous, active-low reset
//   uart_rx  in   serial line, idles high, asynchronous to clk
//   rx_if    master modport of uart_rx_os_if (rx_data, rx_valid, rx_ack,
//            rx_busy, frame_err, overrun_err)
// -----------------------------------------------------------------------------
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         uart_rx,
  uart_rx_os_if.master rx_if
);

  localparam int unsigned     OS_W     = $clog2(OVERSAMPLE);
  localparam logic [32:0]     TICK_INC = 33'(BAUD * OVERSAMPLE);
  localparam logic [32:0]     CLK_DIV  = 33'(CLK_FREQ);
  localparam logic [OS_W-1:0] OS_ONE   = OS_W'(1);
  localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
  // Three vote samples straddle the bit centre at OVERSAMPLE/2.
  localparam logic [OS_W-1:0] VOTE_A   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] VOTE_B   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] VOTE_C   = OS_W'(OVERSAMPLE / 2 + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchroniser and edge history
  logic            sync1_r;
  logic            rxs_r;
  logic            rxs_prev_r;
  // Tick generator
  logic [31:0]     acc_r;
  logic            tick_r;
  logic [32:0]     acc_sum_s;
  logic [31:0]     acc_next_s;
  logic            tick_next_s;
  // Oversample position and vote samples
  logic [OS_W-1:0] os_cnt_r;
  logic [OS_W-1:0] os_next_s;
  logic            samp_a_r;
  logic            samp_b_r;
  logic            vote_pt_s;
  logic            vote_bit_s;
  // Frame FSM
  logic [2:0]      state_r;
  logic [2:0]      state_next_s;
  logic [2:0]      bit_cnt_r;
  logic [2:0]      bit_cnt_next_s;
  logic [7:0]      shift_r;
  logic [7:0]      shift_next_s;
  logic            start_edge_s;
  logic            deliver_s;
  logic            frame_err_s;
  // Registered outputs
  logic [7:0]      rx_data_r;
  logic            rx_valid_r;
  logic            rx_busy_r;
  logic            frame_err_r;
  logic            overrun_err_r;

  assign rx_if.rx_data     = rx_data_r;
  assign rx_if.rx_valid    = rx_valid_r;
  assign rx_if.rx_busy     = rx_busy_r;
  assign rx_if.frame_err   = frame_err_r;
  assign rx_if.overrun_err = overrun_err_r;

  // Bring the asynchronous line into the clk domain and keep the previous value for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r    <= 1'b1;
      rxs_r      <= 1'b1;
      rxs_prev_r <= 1'b1;
    end else begin
      sync1_r    <= uart_rx;
      rxs_r      <= sync1_r;
      rxs_prev_r <= rxs_r;
    end
  end

  // Fractional accumulator: one tick each time BAUD*OVERSAMPLE accumulates past CLK_FREQ.
  always_comb begin
    acc_sum_s = {1'b0, acc_r} + TICK_INC;
    if (acc_sum_s >= CLK_DIV) begin
      acc_next_s  = 32'(acc_sum_s - CLK_DIV);
      tick_next_s = 1'b1;
    end else begin
      acc_next_s  = acc_sum_s[31:0];
      tick_next_s = 1'b0;
    end
  end

  // Oversample position after this tick, and the vote decision at the third sample.
  always_comb begin
    if (os_cnt_r == OS_LAST) begin
      os_next_s = {OS_W{1'b0}};
    end else begin
      os_next_s = os_cnt_r + OS_ONE;
    end
    vote_pt_s    = tick_r && (os_next_s == VOTE_C);
    vote_bit_s   = majority3(samp_a_r, samp_b_r, rxs_r);
    start_edge_s = (state_r == ST_IDLE) && rxs_prev_r && !rxs_r;
  end

  // Tick generator state; restarting at the start edge aligns the bit grid to the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r  <= 32'd0;
      tick_r <= 1'b0;
    end else if (start_edge_s) begin
      acc_r  <= 32'd0;
      tick_r <= 1'b0;
    end else begin
      acc_r  <= acc_next_s;
      tick_r <= tick_next_s;
    end
  end

  // Oversample counter and the first two vote samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      os_cnt_r <= {OS_W{1'b0}};
      samp_a_r <= 1'b1;
      samp_b_r <= 1'b1;
    end else begin
      if (start_edge_s) begin
        os_cnt_r <= {OS_W{1'b0}};
      end else if (tick_r) begin
        os_cnt_r <= os_next_s;
      end else begin
        os_cnt_r <= os_cnt_r;
      end
      if (tick_r && (os_next_s == VOTE_A)) begin
        samp_a_r <= rxs_r;
      end else begin
        samp_a_r <= samp_a_r;
      end
      if (tick_r && (os_next_s == VOTE_B)) begin
        samp_b_r <= rxs_r;
      end else begin
        samp_b_r <= samp_b_r;
      end
    end
  end

  // Frame FSM next-state: start qualification, data shift, stop check, break wait.
  always_comb begin
    state_next_s   = state_r;
    bit_cnt_next_s = bit_cnt_r;
    shift_next_s   = shift_r;
    deliver_s      = 1'b0;
    frame_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (vote_pt_s) begin
          if (vote_bit_s) begin
            state_next_s = ST_IDLE;   // too short to be a start bit
          end else begin
            state_next_s   = ST_DATA;
            bit_cnt_next_s = 3'd0;
          end
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (vote_pt_s) begin
          shift_next_s = {vote_bit_s, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_next_s = ST_STOP;
          end else begin
            bit_cnt_next_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (vote_pt_s) begin
          if (vote_bit_s) begin
            // Return before the stop bit ends so a back-to-back start edge is not missed.
            deliver_s    = 1'b1;
            state_next_s = ST_IDLE;
          end else begin
            frame_err_s  = 1'b1;
            state_next_s = ST_BREAK;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rxs_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BREAK;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Frame FSM state, bit counter and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
    end else begin
      state_r   <= state_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      shift_r   <= shift_next_s;
    end
  end

  // Holding register, handshake and status pulses; a delivery beats a same-cycle ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_r     <= 8'd0;
      rx_valid_r    <= 1'b0;
      rx_busy_r     <= 1'b0;
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
    end else begin
      rx_busy_r   <= (state_next_s != ST_IDLE);
      frame_err_r <= frame_err_s;
      if (deliver_s) begin
        rx_data_r     <= shift_r;
        rx_valid_r    <= 1'b1;
        overrun_err_r <= rx_valid_r & ~rx_if.rx_ack;
      end else if (rx_if.rx_ack && rx_valid_r) begin
        rx_data_r     <= rx_data_r;
        rx_valid_r    <= 1'b0;
        overrun_err_r <= 1'b0;
      end else begin
        rx_data_r     <= rx_data_r;
        rx_valid_r    <= rx_valid_r;
        overrun_err_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os
// Self-checking bench for uart_rx_os at default parameters (434 clk per bit).
// A frame-level model (expected byte, valid flag, pulse counts) is updated per
// transmitted frame / ack / reset and compared with the DUT after each frame.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;
  localparam int BIT_CLK = 434;

  logic clk;
  logic rst;
  logic uart_rx;

  uart_rx_os_if rx_if ();

  uart_rx_os #(
    .CLK_FREQ   (50000000),
    .BAUD       (115200),
    .OVERSAMPLE (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .rx_if   (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed-event counters (sampled on the falling edge)
  int   cyc = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   v_fall = 0;
  int   long_pulse = 0;
  int   rise_cyc = 0;
  logic prev_fe = 1'b0;
  logic prev_ov = 1'b0;
  logic prev_v = 1'b0;

  // Frame-level reference model
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'd0;
  int         exp_fe = 0;
  int         exp_ov = 0;

  int frame_start_cyc = 0;
  int lat_nom = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_if.frame_err && prev_fe) long_pulse <= long_pulse + 1;
    if (rx_if.frame_err && !prev_fe) fe_cnt <= fe_cnt + 1;
    if (rx_if.overrun_err && prev_ov) long_pulse <= long_pulse + 1;
    if (rx_if.overrun_err && !prev_ov) ov_cnt <= ov_cnt + 1;
    if (rx_if.rx_valid && !prev_v) rise_cyc <= cyc;
    if (!rx_if.rx_valid && prev_v) v_fall <= v_fall + 1;
    prev_fe <= rx_if.frame_err;
    prev_ov <= rx_if.overrun_err;
    prev_v  <= rx_if.rx_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame; optional 1-clk inverted spike at each data-bit centre.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_clk,
                            input bit spikes);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    frame_start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      if (spikes && i >= 1 && i <= 8) begin
        wait_clks(bit_clk / 2);
        uart_rx = ~frame[i];
        wait_clks(1);
        uart_rx = frame[i];
        wait_clks(bit_clk - bit_clk / 2 - 1);
      end else begin
        wait_clks(bit_clk);
      end
    end
  endtask

  // Model: a frame ends; a good stop delivers (overrun if the old byte is unread).
  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      if (exp_valid) exp_ov++;
      exp_valid = 1'b1;
      exp_data  = b;
    end else begin
      exp_fe++;
    end
  endtask

  task automatic ack_pulse();
    rx_if.rx_ack = 1'b1;
    wait_clks(1);
    rx_if.rx_ack = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic compare_state(input string tag);
    check_eq({tag, ".valid"}, 32'(rx_if.rx_valid), 32'(exp_valid));
    check_eq({tag, ".data"}, 32'(rx_if.rx_data), 32'(exp_data));
    check_eq({tag, ".frame_err_cnt"}, 32'(fe_cnt), 32'(exp_fe));
    check_eq({tag, ".overrun_cnt"}, 32'(ov_cnt), 32'(exp_ov));
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    int target;
    int vf_before;
    logic [7:0] rb;
    int rclk;
    logic rstop;

    rst = 1'b1;
    uart_rx = 1'b1;
    rx_if.rx_ack = 1'b0;
    #1 rst = 1'b0;
    wait_clks(5);

    // Reset state
    check_eq("rst.rx_data", 32'(rx_if.rx_data), 32'h0);
    check_eq("rst.rx_valid", 32'(rx_if.rx_valid), 32'h0);
    check_eq("rst.rx_busy", 32'(rx_if.rx_busy), 32'h0);
    check_eq("rst.frame_err", 32'(rx_if.frame_err), 32'h0);
    check_eq("rst.overrun_err", 32'(rx_if.overrun_err), 32'h0);
    rst = 1'b1;
    wait_clks(50);

    // 1: single byte, latency, hold, ack
    send_frame(8'hA5, 1'b1, BIT_CLK, 1'b0);
    wait_clks(2);
    model_frame(8'hA5, 1'b1);
    compare_state("t1");
    lat = rise_cyc - frame_start_cyc;
    lat_nom = lat;
    check_eq("t1.latency_window", 32'(lat >= 4095 && lat <= 4165), 32'h1);
    wait_clks(200);
    check_eq("t1.held", 32'(rx_if.rx_valid), 32'h1);
    ack_pulse();
    check_eq("t1.ack_clears", 32'(rx_if.rx_valid), 32'h0);
    wait_clks(100);

    // 2: short low glitch
    uart_rx = 1'b0;
    wait_clks(100);
    check_eq("t2.busy_set", 32'(rx_if.rx_busy), 32'h1);
    uart_rx = 1'b1;
    n = 0;
    while (rx_if.rx_busy && n < BIT_CLK) begin
      wait_clks(1);
      n++;
    end
    check_eq("t2.busy_clear", 32'(rx_if.rx_busy), 32'h0);
    wait_clks(BIT_CLK);
    compare_state("t2");

    // 3: bad stop bit, line held low, then recovery
    send_frame(8'h3C, 1'b0, BIT_CLK, 1'b0);
    wait_clks(2 * BIT_CLK);
    model_frame(8'h3C, 1'b0);
    check_eq("t3.busy_in_break", 32'(rx_if.rx_busy), 32'h1);
    compare_state("t3");
    uart_rx = 1'b1;
    wait_clks(6);
    check_eq("t3.busy_released", 32'(rx_if.rx_busy), 32'h0);
    wait_clks(BIT_CLK);
    send_frame(8'h81, 1'b1, BIT_CLK, 1'b0);
    wait_clks(2);
    model_frame(8'h81, 1'b1);
    compare_state("t3.next");
    ack_pulse();
    wait_clks(100);

    // 4a: back-to-back, no ack -> overrun
    send_frame(8'h00, 1'b1, BIT_CLK, 1'b0);
    model_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1, BIT_CLK, 1'b0);
    wait_clks(2);
    model_frame(8'hFF, 1'b1);
    compare_state("t4.overrun");
    ack_pulse();
    wait_clks(100);

    // 4b: back-to-back with ack on the delivery clock -> no overrun, valid never drops
    send_frame(8'h12, 1'b1, BIT_CLK, 1'b0);
    model_frame(8'h12, 1'b1);
    vf_before = v_fall;
    fork
      send_frame(8'h34, 1'b1, BIT_CLK, 1'b0);
      begin
        #2;
        target = frame_start_cyc + lat_nom - 1;
        n = 0;
        while (cyc != target && n < 6000) begin
          @(posedge clk);
          #1;
          n++;
        end
        check_eq("t4.ack_aligned", 32'(cyc), 32'(target));
        rx_if.rx_ack = 1'b1;
        wait_clks(1);
        rx_if.rx_ack = 1'b0;
      end
    join
    wait_clks(2);
    exp_valid = 1'b1;
    exp_data  = 8'h34;
    compare_state("t4.ack_same_clk");
    check_eq("t4.valid_no_drop", 32'(v_fall), 32'(vf_before));

    // 5: reset during data bit 3 (unread byte 0x34 still held)
    fork
      send_frame(8'h5A, 1'b1, BIT_CLK, 1'b0);
      begin
        wait_clks(BIT_CLK * 4 + BIT_CLK / 2);
        check_eq("t5.busy_before", 32'(rx_if.rx_busy), 32'h1);
        rst = 1'b0;
        #1;
        check_eq("t5.rst_valid", 32'(rx_if.rx_valid), 32'h0);
        check_eq("t5.rst_data", 32'(rx_if.rx_data), 32'h0);
        check_eq("t5.rst_busy", 32'(rx_if.rx_busy), 32'h0);
      end
    join
    wait_clks(2);
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    compare_state("t5.in_reset");
    rst = 1'b1;
    wait_clks(BIT_CLK);
    send_frame(8'h5A, 1'b1, BIT_CLK, 1'b0);
    wait_clks(2);
    model_frame(8'h5A, 1'b1);
    compare_state("t5.after");
    ack_pulse();
    wait_clks(BIT_CLK);

    // 6: +/-3% baud with mid-bit spikes
    send_frame(8'h55, 1'b1, 447, 1'b1);
    wait_clks(2);
    model_frame(8'h55, 1'b1);
    compare_state("t6.slow");
    ack_pulse();
    wait_clks(BIT_CLK);
    send_frame(8'h55, 1'b1, 421, 1'b1);
    wait_clks(2);
    model_frame(8'h55, 1'b1);
    compare_state("t6.fast");
    ack_pulse();
    wait_clks(BIT_CLK);

    // Random frames: random byte, baud error, stop bit, ack and gap
    for (int i = 0; i < 4; i++) begin
      rb    = 8'($urandom);
      rclk  = $urandom_range(421, 447);
      rstop = ($urandom_range(0, 3) != 0);
      send_frame(rb, rstop, rclk, 1'b0);
      wait_clks(2);
      model_frame(rb, rstop);
      compare_state($sformatf("rnd%0d", i));
      uart_rx = 1'b1;
      if ($urandom_range(0, 1) == 1) ack_pulse();
      wait_clks($urandom_range(20, 400));
    end

    check_eq("pulse_width", 32'(long_pulse), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
